// File: rtl/fb_pkg.sv
// fb_pkg: mode encodings, sequencer states and pipeline latency for the feedback combiner
package fb_pkg;
    localparam logic [1:0] FB_MODE_FB      = 2'b00;
    localparam logic [1:0] FB_MODE_CONST   = 2'b01;
    localparam logic [1:0] FB_MODE_UNGATED = 2'b10;
    localparam logic [1:0] FB_MODE_OFF     = 2'b11;

    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, GAP} fb_state_t;

    function automatic int fb_latency(input int n_ch);
        return 3 + $clog2(n_ch);
    endfunction
endpackage

// File: rtl/fb_window_gen.sv
// fb_window_gen: trigger edge detect and multi-bunch window sequencer producing gate and busy
module fb_window_gen
    import fb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic [2:0]       no_bunches,
    input  logic [3:0]       no_samples,
    input  logic [CNT_W-1:0] sample_spacing,
    input  logic [CNT_W-1:0] start_delay,
    output logic             gate,
    output logic             busy
);
    fb_state_t        state;
    logic             trig_d;
    logic             go;
    logic [2:0]       bunches;
    logic [3:0]       samples;
    logic [CNT_W-1:0] spacing;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] win;

    assign go   = trig && !trig_d && no_bunches != 3'd0 && no_samples != 4'd0;
    assign win  = CNT_W'(samples) - CNT_W'(1);
    assign gate = state == ACTIVE;
    assign busy = state != IDLE;

    // cnt holds the remaining cycles of the current state minus one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            trig_d  <= 1'b0;
            bunches <= '0;
            samples <= '0;
            spacing <= '0;
            cnt     <= '0;
        end else begin
            trig_d <= trig;
            case (state)
                IDLE: if (go) begin
                    bunches <= no_bunches;
                    samples <= no_samples;
                    spacing <= sample_spacing;
                    state   <= start_delay == '0 ? ACTIVE : DELAY;
                    cnt     <= start_delay == '0 ? CNT_W'(no_samples) - CNT_W'(1) : start_delay - CNT_W'(1);
                end
                DELAY: begin
                    state <= cnt == '0 ? ACTIVE : DELAY;
                    cnt   <= cnt == '0 ? win : cnt - CNT_W'(1);
                end
                ACTIVE: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    else if (bunches == 3'd1) state <= IDLE;
                    else begin
                        bunches <= bunches - 3'd1;
                        state   <= spacing > CNT_W'(samples) ? GAP : ACTIVE;
                        cnt     <= spacing > CNT_W'(samples) ? spacing - CNT_W'(samples) - CNT_W'(1) : win;
                    end
                end
                GAP: begin
                    state <= cnt == '0 ? ACTIVE : GAP;
                    cnt   <= cnt == '0 ? win : cnt - CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/fb_combiner_n.sv
// fb_combiner_n: gain-scales N_CH channels, sums them in a registered tree, clamps and gates to the DAC
module fb_combiner_n
    import fb_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 15,
    parameter int COEF_W    = 18,
    parameter int FRAC_BITS = 14,
    parameter int OUT_W     = 13,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trig,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    input  logic [N_CH*COEF_W-1:0]   coef,
    input  logic [N_CH-1:0]          ch_en,
    input  logic [1:0]               mode,
    input  logic [OUT_W-1:0]         const_dac,
    input  logic [2:0]               no_bunches,
    input  logic [3:0]               no_samples,
    input  logic [CNT_W-1:0]         sample_spacing,
    input  logic [CNT_W-1:0]         start_delay,
    input  logic                     sat_clr,
    output logic [OUT_W-1:0]         fb_sgnl,
    output logic                     dac_cond,
    output logic                     busy,
    output logic                     sat_flag
);
    localparam int LAT = fb_latency(N_CH);
    localparam int PW  = DATA_W + COEF_W;
    localparam int TW  = PW - FRAC_BITS + $clog2(N_CH);
    localparam logic signed [PW-1:0] RND  = PW'(1 << (FRAC_BITS - 1));
    localparam logic signed [TW-1:0] MAXV = TW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [TW-1:0] MINV = TW'(-(1 << (OUT_W - 1)));

    logic                    gate;
    logic                    g;
    logic [LAT-2:0]          gsr;
    logic signed [PW-1:0]    mul  [N_CH];
    logic signed [PW-1:0]    prod [N_CH];
    logic signed [TW-1:0]    node [2*N_CH-1];
    logic signed [OUT_W-1:0] clamped;
    logic                    sat;
    logic                    drive;

    fb_window_gen #(.CNT_W(CNT_W)) u_win (
        .clk            (clk),
        .rst_n          (rst_n),
        .trig           (trig),
        .no_bunches     (no_bunches),
        .no_samples     (no_samples),
        .sample_spacing (sample_spacing),
        .start_delay    (start_delay),
        .gate           (gate),
        .busy           (busy)
    );

    always_comb begin
        for (int i = 0; i < N_CH; i++)
            mul[i] = PW'($signed(data_in[i*DATA_W +: DATA_W])) * PW'($signed(coef[i*COEF_W +: COEF_W]));
    end

    // heap-ordered tree: node n sums nodes 2n+1 and 2n+2, leaves start at N_CH-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) prod[i] <= '0;
            for (int n = 0; n < 2*N_CH-1; n++) node[n] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                prod[i]        <= ch_en[i] ? mul[i] : '0;
                node[N_CH-1+i] <= TW'((prod[i] + RND) >>> FRAC_BITS);
            end
            for (int n = 0; n < N_CH-1; n++) node[n] <= node[2*n+1] + node[2*n+2];
        end
    end

    assign g = gsr[LAT-2];

    always_comb begin
        sat     = node[0] > MAXV || node[0] < MINV;
        clamped = node[0] > MAXV ? MAXV[OUT_W-1:0] : node[0] < MINV ? MINV[OUT_W-1:0] : node[0][OUT_W-1:0];
        drive   = mode == FB_MODE_UNGATED || (mode == FB_MODE_FB && g);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gsr      <= '0;
            fb_sgnl  <= '0;
            dac_cond <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            gsr      <= {gsr[LAT-3:0], gate};
            fb_sgnl  <= drive ? clamped : (mode == FB_MODE_CONST && g) ? const_dac : '0;
            dac_cond <= mode == FB_MODE_UNGATED || (g && mode != FB_MODE_OFF);
            sat_flag <= (drive && sat) || (sat_flag && !sat_clr);
        end
    end
endmodule

// File: tb/tb_fb_combiner_n.sv
// tb_fb_combiner_n: directed literal checks plus random stimulus against a cycle-indexed behavioural model
module tb_fb_combiner_n;
    localparam int N_CH = 4, DATA_W = 15, COEF_W = 18, FRAC_BITS = 14, OUT_W = 13, CNT_W = 8;
    localparam int LAT = 5, MAXC = 4096;
    localparam int MAXO = 2**(OUT_W-1) - 1, MINO = -(2**(OUT_W-1));

    logic clk = 0, rst_n = 0, trig = 0, sat_clr = 0;
    logic [N_CH*DATA_W-1:0] data_in = '0;
    logic [N_CH*COEF_W-1:0] coef = '0;
    logic [N_CH-1:0] ch_en = '1;
    logic [1:0] mode = 2'b00;
    logic [OUT_W-1:0] const_dac = '0;
    logic [2:0] no_bunches = '0;
    logic [3:0] no_samples = '0;
    logic [CNT_W-1:0] sample_spacing = '0, start_delay = '0;
    logic [OUT_W-1:0] fb_sgnl;
    logic dac_cond, busy, sat_flag;

    int total = 0, bad = 0, cyc = 0;
    int val_a[MAXC], mode_a[MAXC], const_a[MAXC];
    bit gate_a[MAXC], sat_a[MAXC], clr_a[MAXC], rst_a[MAXC];
    int bstart = -100, blast = -100;
    bit tp = 0, es = 0;

    fb_combiner_n dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .data_in(data_in), .coef(coef), .ch_en(ch_en),
        .mode(mode), .const_dac(const_dac), .no_bunches(no_bunches), .no_samples(no_samples),
        .sample_spacing(sample_spacing), .start_delay(start_delay), .sat_clr(sat_clr),
        .fb_sgnl(fb_sgnl), .dac_cond(dac_cond), .busy(busy), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int c);
        while (cyc < c) step();
        @(negedge clk);
    endtask

    task automatic set_data(input int d0, input int d1, input int d2, input int d3);
        data_in = {DATA_W'(d3), DATA_W'(d2), DATA_W'(d1), DATA_W'(d0)};
    endtask

    task automatic set_coef(input int c0, input int c1, input int c2, input int c3);
        coef = {COEF_W'(c3), COEF_W'(c2), COEF_W'(c1), COEF_W'(c0)};
    endtask

    task automatic fire(input int nb, input int ns, input int sp, input int dl, output int k);
        step();
        no_bunches = 3'(nb);
        no_samples = 4'(ns);
        sample_spacing = CNT_W'(sp);
        start_delay = CNT_W'(dl);
        trig = 1;
        k = cyc;
        step();
        trig = 0;
    endtask

    // weighted, rounded, summed and clamped value of the current inputs
    function automatic void calc(output int v, output bit s);
        longint acc = 0;
        longint p;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_en[i]) begin
                p = longint'($signed(data_in[i*DATA_W +: DATA_W])) * longint'($signed(coef[i*COEF_W +: COEF_W]));
                acc += (p + longint'(1 << (FRAC_BITS - 1))) >>> FRAC_BITS;
            end
        end
        s = acc > MAXO || acc < MINO;
        v = acc > MAXO ? MAXO : acc < MINO ? MINO : int'(acc);
    endfunction

    always @(negedge clk) begin
        int c, v, per, m, efb, edc, eb, lo;
        bit s, g, drv;
        c = cyc;
        if (c < MAXC - 300) begin
            rst_a[c] = !rst_n;
            mode_a[c] = int'(mode);
            const_a[c] = int'($signed(const_dac));
            clr_a[c] = sat_clr;
            eb = 0;
            if (!rst_n) begin
                lo = c >= LAT ? c - LAT : 0;
                for (int i = lo; i < MAXC; i++) gate_a[i] = 0;
                for (int i = lo; i <= c; i++) begin
                    val_a[i] = 0;
                    sat_a[i] = 0;
                end
                bstart = -100;
                blast = -100;
                tp = 0;
                es = 0;
            end else begin
                calc(v, s);
                val_a[c] = v;
                sat_a[c] = s;
                eb = (c > bstart && c <= blast) ? 1 : 0;
                if (trig && !tp && eb == 0 && no_bunches != 0 && no_samples != 0) begin
                    per = sample_spacing > no_samples ? int'(sample_spacing) : int'(no_samples);
                    for (int b = 0; b < int'(no_bunches); b++)
                        for (int j = 0; j < int'(no_samples); j++)
                            gate_a[c + 1 + int'(start_delay) + b*per + j] = 1;
                    bstart = c;
                    blast = c + int'(start_delay) + (int'(no_bunches) - 1)*per + int'(no_samples);
                end
                tp = trig;
            end
            if (c >= LAT) begin
                if (rst_a[c] || rst_a[c-1]) begin
                    efb = 0;
                    edc = 0;
                    es = 0;
                end else begin
                    m = mode_a[c-1];
                    g = gate_a[c-LAT];
                    drv = m == 2 || (m == 0 && g);
                    efb = drv ? val_a[c-LAT] : (m == 1 && g) ? const_a[c-1] : 0;
                    edc = (m == 2 || (g && m != 3)) ? 1 : 0;
                    es = (drv && sat_a[c-LAT]) || (es && !clr_a[c-1]);
                end
                chk("fb_sgnl", $signed(fb_sgnl), efb);
                chk("dac_cond", int'(dac_cond), edc);
                chk("busy", int'(busy), eb);
                chk("sat_flag", int'(sat_flag), int'(es));
            end
        end
    end

    initial begin
        int k, c0;
        set_coef(16384, 16384, 16384, 16384);
        set_data(100, 200, -50, 25);
        repeat (3) step();
        @(negedge clk);
        chk("rst_fb", $signed(fb_sgnl), 0);
        chk("rst_busy", int'(busy), 0);
        step();
        rst_n = 1;
        repeat (3) step();

        fire(1, 1, 1, 0, k);
        at(k + 5); chk("sum_early", $signed(fb_sgnl), 0);
        at(k + 6); chk("sum_val", $signed(fb_sgnl), 275); chk("sum_dac", int'(dac_cond), 1);
        at(k + 7); chk("sum_late", $signed(fb_sgnl), 0); chk("sum_dac_late", int'(dac_cond), 0);

        set_data(4000, 4000, 4000, 4000);
        fire(1, 1, 1, 0, k);
        at(k + 6); chk("sat_pos", $signed(fb_sgnl), 4095); chk("sat_flag_pos", int'(sat_flag), 1);
        set_data(-4000, -4000, -4000, -4000);
        fire(1, 1, 1, 0, k);
        at(k + 6); chk("sat_neg", $signed(fb_sgnl), -4096);
        step(); sat_clr = 1; c0 = cyc;
        step(); sat_clr = 0;
        at(c0 + 1); chk("sat_clr", int'(sat_flag), 0);
        set_data(4000, 4000, 4000, 4000);
        fire(1, 1, 1, 0, k);
        while (cyc < k + 5) step();
        sat_clr = 1;
        step(); sat_clr = 0;
        @(negedge clk); chk("sat_set_wins", int'(sat_flag), 1);

        set_coef(8192, 16384, 16384, 16384);
        set_data(1, 0, 0, 0);
        fire(1, 1, 1, 0, k);
        at(k + 6); chk("round_up", $signed(fb_sgnl), 1);
        set_data(-1, 0, 0, 0);
        fire(1, 1, 1, 0, k);
        at(k + 6); chk("round_neg", $signed(fb_sgnl), 0); chk("round_neg_dac", int'(dac_cond), 1);
        set_data(1, 1000, 1000, 1000);
        ch_en = 4'b0001;
        fire(1, 1, 1, 0, k);
        at(k + 6); chk("ch_en", $signed(fb_sgnl), 1);
        ch_en = 4'b1111;
        set_coef(16384, 16384, 16384, 16384);

        set_data(10, 20, 30, 40);
        fire(3, 2, 5, 3, k);
        for (int i = 1; i <= 22; i++) begin
            while (cyc < k + i) step();
            trig = (i == 8);
            @(negedge clk);
            chk("mb_dac", int'(dac_cond), (i inside {9, 10, 14, 15, 19, 20}) ? 1 : 0);
            chk("mb_busy", int'(busy), i <= 15 ? 1 : 0);
        end
        trig = 0;

        set_data(100, 200, -50, 25);
        step();
        mode = 2'b01;
        const_dac = OUT_W'(-1234);
        fire(1, 1, 1, 0, k);
        at(k + 6); chk("const_val", $signed(fb_sgnl), -1234);
        at(k + 7); chk("const_off", $signed(fb_sgnl), 0);
        step();
        mode = 2'b10;
        c0 = cyc;
        at(c0 + 6); chk("ungated_val", $signed(fb_sgnl), 275); chk("ungated_dac", int'(dac_cond), 1);
        step();
        mode = 2'b11;
        fire(1, 1, 1, 0, k);
        at(k + 6); chk("off_val", $signed(fb_sgnl), 0); chk("off_dac", int'(dac_cond), 0);
        mode = 2'b00;
        fire(0, 1, 1, 0, k);
        at(k + 1); chk("nb0_busy", int'(busy), 0);
        at(k + 6); chk("nb0_dac", int'(dac_cond), 0);

        fire(1, 8, 1, 0, k);
        at(k + 7); chk("pre_rst_val", $signed(fb_sgnl), 275); chk("pre_rst_busy", int'(busy), 1);
        while (cyc < k + 8) step();
        rst_n = 0;
        #1;
        chk("async_fb", $signed(fb_sgnl), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_dac", int'(dac_cond), 0);
        step();
        step();
        rst_n = 1;
        fire(1, 1, 1, 0, k);
        at(k + 1); chk("post_rst_busy", int'(busy), 1);
        at(k + 6); chk("post_rst_val", $signed(fb_sgnl), 275);

        for (int n = 0; n < 600; n++) begin
            step();
            for (int i = 0; i < N_CH; i++) begin
                data_in[i*DATA_W +: DATA_W] = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 600) - 300);
                coef[i*COEF_W +: COEF_W] = COEF_W'($urandom_range(0, 32768) - 16384);
            end
            ch_en = N_CH'($urandom);
            trig = ($urandom_range(0, 5) == 0);
            no_bunches = 3'($urandom_range(0, 4));
            no_samples = 4'($urandom_range(0, 6));
            sample_spacing = CNT_W'($urandom_range(0, 12));
            start_delay = CNT_W'($urandom_range(0, 10));
            sat_clr = ($urandom_range(0, 15) == 0);
            const_dac = OUT_W'($urandom);
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
        end
        trig = 0;
        sat_clr = 0;
        repeat (10) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
